// File: rtl/blockloader_pkg.sv
// rtl/blockloader_pkg.sv - shared types and constants for the block loader
// Contents: state_t (FILL/ISSUE/WAIT/FIN), WORDS_PER_BLK, PAD_BYTE, byte_swap32().
package blockloader_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FIN   = 2'd3
   } state_t;

   localparam int         WORDS_PER_BLK = 4;
   localparam logic [7:0] PAD_BYTE      = 8'h01;

   // Reverses byte order so a big-endian word lands with its first byte in [7:0].
   function automatic logic [31:0] byte_swap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/blockloader_pad.sv
// rtl/blockloader_pad.sv - combinational padding of a 16-byte block
// Ports:
//   buffer [127:0] in  : collected message bytes, byte i at [8i+7:8i]
//   n      [4:0]   in  : valid byte count in the block (1..16)
//   last           in  : block closes the message
//   m      [128:0] out : padded block; m[128] flags a full block
module blockloader_pad
   import blockloader_pkg::*;
(
   input  logic [127:0] buffer,
   input  logic [4:0]   n,
   input  logic         last,
   output logic [128:0] m
);

   always_comb begin
      m = '0;
      // A block that does not end the message is always full.
      if (!last || n == 5'd16) begin
         m = {1'b1, buffer};
      end else begin
         // Keep bytes below n, put the pad marker at n, zero everything above.
         for (int i = 0; i < WORDS_PER_BLK * 4; i++) begin
            if (5'(i) < n)
               m[8*i +: 8] = buffer[8*i +: 8];
            else if (5'(i) == n)
               m[8*i +: 8] = PAD_BYTE;
         end
      end
   end

endmodule

// File: rtl/blockloader.sv
// rtl/blockloader.sv - collects 32-bit message words into padded 16-byte blocks
// Optional feature macro: BLOCKLOADER_BYTESWAP_EN (big-endian din capture).
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   din[31:0], din_valid, din_ready, din_last, din_bytes[1:0] : word input
//   m[128:0], start    : padded block and its one-cycle launch pulse
//   pb_done            : processing stage completion pulse
//   msg_done           : one-cycle pulse after the final block completes
//   busy               : high except when idle in FILL with no words held
module blockloader
   import blockloader_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic [31:0]  din,
   input  logic         din_valid,
   output logic         din_ready,
   input  logic         din_last,
   input  logic [1:0]   din_bytes,
   output logic [128:0] m,
   output logic         start,
   input  logic         pb_done,
   output logic         msg_done,
   output logic         busy
);

   state_t       state;
   logic [1:0]   k;
   logic         last_flag;
   logic [127:0] buffer;

   logic [31:0]  cap_word;
   logic [127:0] buf_next;
   logic [2:0]   last_b;
   logic [4:0]   n_next;
   logic [128:0] pad_m;
   logic         transfer;
   logic         closing;

`ifdef BLOCKLOADER_BYTESWAP_EN
   assign cap_word = byte_swap32(din);
`else
   assign cap_word = din;
`endif

   assign din_ready = (state == FILL);
   assign transfer  = din_valid & din_ready;
   assign closing   = (k == 2'(WORDS_PER_BLK - 1)) || din_last;

   // The pad stage sees the buffer as it will be after this transfer, so m
   // can be registered on the closing edge and be valid together with start.
   always_comb begin
      buf_next = buffer;
      buf_next[{k, 5'b00000} +: 32] = cap_word;
      if (din_last && din_bytes != 2'd0)
         last_b = {1'b0, din_bytes};
      else
         last_b = 3'd4;
      n_next = {1'b0, k, 2'b00} + {2'b00, last_b};
   end

   blockloader_pad u_pad (
      .buffer (buf_next),
      .n      (n_next),
      .last   (din_last),
      .m      (pad_m)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FILL;
         k         <= 2'd0;
         last_flag <= 1'b0;
         buffer    <= '0;
         m         <= '0;
         start     <= 1'b0;
         msg_done  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (transfer) begin
                  buffer <= buf_next;
                  busy   <= 1'b1;
                  if (closing) begin
                     m         <= pad_m;
                     k         <= 2'd0;
                     last_flag <= din_last;
                     start     <= 1'b1;
                     state     <= ISSUE;
                  end else begin
                     k <= k + 2'd1;
                  end
               end
            end
            ISSUE: begin
               start <= 1'b0;
               state <= WAIT;
            end
            WAIT: begin
               if (pb_done) begin
                  if (last_flag) begin
                     msg_done <= 1'b1;
                     state    <= FIN;
                  end else begin
                     k     <= 2'd0;
                     busy  <= 1'b0;
                     state <= FILL;
                  end
               end
            end
            FIN: begin
               msg_done  <= 1'b0;
               last_flag <= 1'b0;
               buffer    <= '0;
               k         <= 2'd0;
               busy      <= 1'b0;
               state     <= FILL;
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule
